// File: rtl/jk_counter_pkg.sv
// Shared JK excitation definitions for counters built from discrete JK cells.
// Pairs are encoded as {J,K}.
package jk_counter_pkg;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t JK_HOLD   = 2'b00;
  localparam jk_mode_t JK_RESET  = 2'b01;
  localparam jk_mode_t JK_SET    = 2'b10;
  localparam jk_mode_t JK_TOGGLE = 2'b11;

  // Set/reset-only excitation: the toggle pair can never come out of this,
  // so the cell result does not depend on its present state.
  function automatic jk_mode_t jk_excite(input logic cur, input logic nxt);
    return {nxt & ~cur, ~nxt & cur};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK storage element with synchronous active-high reset to 0.
module jk_cell
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state lives in WIDTH JK cells; this
// level computes the next count, its J/K excitation, tc, and the wrap/err pulses.
module jk_updown_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("jk_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the din check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0]      nxt;
  logic [WIDTH-1:0][1:0] jk_pair;
  logic                  at_max;
  logic                  at_zero;
  logic                  din_ok;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;

  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);
  assign din_ok  = ({1'b0, din} < MOD_EXT);

  // Wrap points are explicit compares, never reliance on WIDTH-bit overflow.
  always_comb begin
    nxt    = q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      nxt   = din_ok ? din : '0;
      err_d = ~din_ok;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          nxt    = '0;
          wrap_d = 1'b1;
        end else begin
          nxt = q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          nxt    = MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          nxt = q - WIDTH'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign jk_pair[i] = jk_excite(q[i], nxt[i]);

    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk_pair[i][1]),
      .k   (jk_pair[i][0]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign tc   = (up & at_max) | (~up & at_zero);
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench: MODULUS=10 main instance plus MODULUS=16 and MODULUS=2 variants
// sharing the control inputs.
module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] din;
  logic [0:0] din2;
  logic [3:0] q10, q16;
  logic [0:0] q2;
  logic       tc10, tc16, tc2;
  logic       wrap10, wrap16, wrap2;
  logic       err10, err16, err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q10), .tc(tc10), .wrap(wrap10), .err(err10)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q16), .tc(tc16), .wrap(wrap16), .err(err16)
  );

  jk_updown_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din2),
    .q(q2), .tc(tc2), .wrap(wrap2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic has_toggle(input logic [7:0] p);
    for (int b = 0; b < 4; b++)
      if (p[2*b +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0; din2 = 1'b0;
    tick(); tick();
    chk("rst_q", q10, 0);
    chk("rst_wrap", wrap10, 0);
    chk("rst_err", err10, 0);
    chk("rst_tc_up", tc10, 0);
    up = 1'b0; #1;
    chk("rst_tc_down", tc10, 1);

    // Up-count through the wrap
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      chk("up_no_toggle", has_toggle(dut.jk_pair), 0);
      if (k == 8) chk("jk_7_to_8", dut.jk_pair, 8'b10_01_01_01);
      tick();
      chk("up_q", q10, k % 10);
      chk("up_wrap", wrap10, (k == 10));
      chk("up_tc", tc10, ((k % 10) == 9));
    end

    // Down-count wrap
    rst = 1'b1; tick();
    chk("rst_mid_q", q10, 0);
    rst = 1'b0; up = 1'b0; #1;
    chk("dn_tc0", tc10, 1);
    tick();
    chk("dn_q9", q10, 9);  chk("dn_wrap9", wrap10, 1); chk("dn_tc9", tc10, 0);
    tick();
    chk("dn_q8", q10, 8);  chk("dn_wrap8", wrap10, 0);
    tick();
    chk("dn_q7", q10, 7);

    // Loads
    en = 1'b0; load = 1'b1; din = 4'd7; tick();
    chk("ld7_q", q10, 7); chk("ld7_err", err10, 0);
    din = 4'd12; tick();
    chk("ld12_q", q10, 0); chk("ld12_err", err10, 1); chk("ld12_wrap", wrap10, 0);
    load = 1'b0; tick();
    chk("ld12_err_clr", err10, 0); chk("ld12_hold", q10, 0);
    load = 1'b1; din = 4'd9; tick();
    chk("ld9_q", q10, 9);
    up = 1'b1; en = 1'b1; din = 4'd3; #1;
    chk("ld9_tc", tc10, 1);
    tick();
    chk("ld_over_en_q", q10, 3); chk("ld_over_en_wrap", wrap10, 0);

    // Reset beats enable
    din = 4'd5; tick();
    load = 1'b0; rst = 1'b1; tick();
    chk("rst_pri_q", q10, 0); chk("rst_pri_wrap", wrap10, 0);
    rst = 1'b0;

    // Hold: all cells see J=K=0
    load = 1'b1; din = 4'd5; tick();
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_jk", dut.jk_pair, 0);
      tick();
      chk("hold_q", q10, 5);
      chk("hold_wrap", wrap10, 0);
    end

    // Direction flip
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    tick(); tick(); tick(); tick();
    chk("flip_q4", q10, 4);
    up = 1'b0; #1;
    chk("flip_tc4", tc10, 0);
    tick();
    chk("flip_q3", q10, 3); chk("flip_tc3", tc10, 0);
    tick(); tick(); tick();
    chk("flip_q0", q10, 0); chk("flip_tc0", tc10, 1);

    // Full-range modulus 16
    en = 1'b0; up = 1'b1; load = 1'b1; din = 4'd15; tick();
    chk("m16_ld15", q16, 15); chk("m16_ld15_err", err16, 0); chk("m16_tc15", tc16, 1);
    load = 1'b0; en = 1'b1; tick();
    chk("m16_up_q", q16, 0); chk("m16_up_wrap", wrap16, 1);
    up = 1'b0; tick();
    chk("m16_dn_q", q16, 15); chk("m16_dn_wrap", wrap16, 1);

    // Modulus 2: consecutive wraps by alternating direction
    en = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; up = 1'b0; tick();
    chk("m2_q1", q2, 1); chk("m2_wrap1", wrap2, 1);
    up = 1'b1; tick();
    chk("m2_q0", q2, 0); chk("m2_wrap2", wrap2, 1);
    up = 1'b0; tick();
    chk("m2_q1b", q2, 1); chk("m2_wrap3", wrap2, 1);
    en = 1'b0; tick();
    chk("m2_wrap_clr", wrap2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
